// File: rtl/tff_bist_pkg.sv
// Shared types and constants for the tff_s self-test driver.
package tff_bist_pkg;

    // One stimulus step as driven onto the flip-flop under test.
    typedef struct packed {
        logic rst_n;
        logic pre_n;
        logic t;
    } step_t;

    localparam int NSTEPS = 12;
    localparam int STEP_W = 4;

    // Quiet values on the DUT pins whenever no program is running.
    localparam step_t IDLE_DRIVE = 3'b110;

    // Stimulus program, packed as {rst_n, pre_n, t}.
    localparam step_t STEP_TABLE [NSTEPS] = '{
        3'b010, 3'b110, 3'b111, 3'b110, 3'b111, 3'b111,
        3'b110, 3'b100, 3'b110, 3'b111, 3'b001, 3'b110
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Table lookup that falls back to idle values outside the program.
    function automatic step_t step_at(input logic [STEP_W-1:0] idx);
        if (int'(idx) < NSTEPS) begin
            return STEP_TABLE[idx];
        end
        return IDLE_DRIVE;
    endfunction

endpackage

// File: rtl/tff_ref_model.sv
// Golden T flip-flop: reset beats preset beats toggle, advanced only when enabled.
module tff_ref_model
    import tff_bist_pkg::*;
(
    input  logic CLK,
    input  logic rst,
    input  logic en,
    input  logic T,
    input  logic pre_n,
    input  logic rst_n,
    output logic q
);

    // Reference state register, evaluated on the same pin values the DUT sees.
    always_ff @(posedge CLK) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            if (!rst_n) begin
                q <= 1'b0;
            end else if (!pre_n) begin
                q <= 1'b1;
            end else begin
                q <= q ^ T;
            end
        end
    end

endmodule

// File: rtl/tff_bist_driver.sv
// Self-test driver/checker for a tff_s flip-flop sharing CLK: plays a fixed
// 12-step program, compares DUT Q to a golden model and reports the result.
module tff_bist_driver
    import tff_bist_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int ERR_W = 4
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    output logic             T_o,
    output logic             pre_n_o,
    output logic             rst_n_o,
    input  logic             Q_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       first_err_step
);

    localparam int CYC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [STEP_W-1:0]  step;
    logic [CYC_W-1:0]   cyc;
    step_t              drive;
    logic               model_q;
    logic               step_end;
    logic               last_step;
    logic               mismatch;

    assign T_o     = drive.t;
    assign pre_n_o = drive.pre_n;
    assign rst_n_o = drive.rst_n;

    assign step_end  = (cyc == CYC_W'(HOLD - 1));
    assign last_step = (step == STEP_W'(NSTEPS - 1));

    // First cycle of each step is settle time, so sync and async pre/rst DUTs both agree.
    assign mismatch = (state == ST_RUN) && (cyc != '0) && (Q_i != model_q);

    tff_ref_model u_model (
        .CLK   (CLK),
        .rst   (rst),
        .en    (state == ST_RUN),
        .T     (drive.t),
        .pre_n (drive.pre_n),
        .rst_n (drive.rst_n),
        .q     (model_q)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (step_end && last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Step/cycle counters, registered pin drive, error tally and verdict.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            step           <= '0;
            cyc            <= '0;
            drive          <= IDLE_DRIVE;
            err_cnt        <= '0;
            first_err_step <= '0;
            pass           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        step           <= '0;
                        cyc            <= '0;
                        drive          <= step_at(STEP_W'(0));
                        err_cnt        <= '0;
                        first_err_step <= '0;
                        pass           <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (mismatch) begin
                        if (!(&err_cnt)) begin
                            err_cnt <= err_cnt + ERR_W'(1);
                        end
                        if (err_cnt == '0) begin
                            first_err_step <= step;
                        end
                    end
                    if (step_end) begin
                        cyc <= '0;
                        if (last_step) begin
                            drive <= IDLE_DRIVE;
                            // Verdict includes a mismatch found on this final checked cycle.
                            pass  <= (err_cnt == '0) && !mismatch;
                        end else begin
                            step  <= step + STEP_W'(1);
                            drive <= step_at(step + STEP_W'(1));
                        end
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                default: begin
                    drive <= IDLE_DRIVE;
                end
            endcase
        end
    end

endmodule
